// File: rtl/wb_commit.sv
// Writeback/commit stage: merges EX results and in-order load responses onto the single RF write
// port and tracks outstanding load destinations. Optional macro WB_BYPASS_EN enables byp_* forwarding.
module wb_commit #(
  parameter int XLEN     = 32,
  parameter int NREG     = 16,
  parameter int LD_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [$clog2(NREG)-1:0]   ex_rd,
  input  logic [XLEN-1:0]           ex_data,
  input  logic                      ld_issue,
  output logic                      ld_issue_ready,
  input  logic [$clog2(NREG)-1:0]   ld_rd,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rsp_data,
  output logic                      wb_en,
  output logic [$clog2(NREG)-1:0]   wb_addr,
  output logic [XLEN-1:0]           wb_data,
  output logic [NREG-1:0]           busy,
  output logic                      byp_valid,
  output logic [$clog2(NREG)-1:0]   byp_addr,
  output logic [XLEN-1:0]           byp_data,
  output logic                      err
);

  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(LD_DEPTH);

  logic            skid_full_q, skid_full_d;
  logic [AW-1:0]   skid_rd_q, skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;

  logic [AW-1:0]   fifo_q [LD_DEPTH];
  logic [AW-1:0]   fifo_d [LD_DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;

  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_en_q, wb_en_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_q, err_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic [AW-1:0]   head_rd;
  logic            ld_push;
  logic            ld_pop;
  logic            src_valid;
  logic [AW-1:0]   src_rd;
  logic [XLEN-1:0] src_data;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                          (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_rd        = fifo_q[rd_ptr_q[PW-1:0]];
  assign ld_issue_ready = !fifo_full && !busy_q[ld_rd];
  assign ld_push        = ld_issue && ld_issue_ready;
  assign ld_pop         = mem_rsp_valid && !fifo_empty;
  assign ex_ready       = !skid_full_q;

  always_comb begin
    skid_full_d = skid_full_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    busy_d      = busy_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = err_q;
    src_valid   = 1'b0;
    src_rd      = '0;
    src_data    = '0;

    // A response owns the write port; a colliding EX result parks in the skid.
    if (mem_rsp_valid) begin
      if (ld_pop) begin
        src_valid = 1'b1;
        src_rd    = head_rd;
        src_data  = mem_rsp_data;
      end
      if (ex_valid && !skid_full_q) begin
        skid_full_d = 1'b1;
        skid_rd_d   = ex_rd;
        skid_data_d = ex_data;
      end
    end else if (skid_full_q) begin
      src_valid   = 1'b1;
      src_rd      = skid_rd_q;
      src_data    = skid_data_q;
      skid_full_d = 1'b0;
    end else if (ex_valid) begin
      src_valid = 1'b1;
      src_rd    = ex_rd;
      src_data  = ex_data;
    end

    wb_en_d = src_valid && (src_rd != '0);
    if (src_valid) begin
      wb_addr_d = src_rd;
      wb_data_d = src_data;
    end

    if (ld_pop) begin
      rd_ptr_d        = rd_ptr_q + (PW+1)'(1);
      busy_d[head_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle set on the same register wins.
    if (ld_push) begin
      fifo_d[wr_ptr_q[PW-1:0]] = ld_rd;
      wr_ptr_d                 = wr_ptr_q + (PW+1)'(1);
      if (ld_rd != '0) begin
        busy_d[ld_rd] = 1'b1;
      end
    end

    if ((ex_valid && skid_full_q) || (ex_valid && busy_q[ex_rd]) ||
        (mem_rsp_valid && fifo_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  // Entries are only read while valid, so storage needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = wb_en_q;
  assign byp_addr  = wb_addr_q;
  assign byp_data  = wb_data_q;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus randomized traffic against a
// queue-based reference model of the commit stage.
module tb_wb_commit;

  localparam int LD_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_issue, ld_issue_ready;
  logic [3:0]  ld_rd;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] busy;
  logic        byp_valid;
  logic [3:0]  byp_addr;
  logic [31:0] byp_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_commit #(.XLEN(32), .NREG(16), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_rd(ld_rd),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data), .err(err)
  );

  // Reference model: outstanding loads in issue order, waiting EX results, expected port values.
  typedef struct { logic [3:0] rd; logic [31:0] data; } ex_t;
  logic [3:0]  pend_q[$];
  ex_t         ex_wait_q[$];
  logic        exp_wb_en;
  logic [3:0]  exp_wb_addr;
  logic [31:0] exp_wb_data;
  logic        exp_err;

  function automatic bit m_busy(logic [3:0] r);
    if (r == 4'd0) return 1'b0;
    foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ld_ready(logic [3:0] r);
    return (pend_q.size() < LD_DEPTH) && !m_busy(r);
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    v = '0;
    for (int r = 0; r < 16; r++) v[r] = m_busy(4'(r));
    return v;
  endfunction

  function automatic void m_step();
    bit          rdy;
    bit          have;
    logic [3:0]  wr;
    logic [31:0] wd;
    ex_t         e;
    rdy  = m_ld_ready(ld_rd);
    have = 1'b0;
    wr   = '0;
    wd   = '0;
    if (ex_valid && ex_wait_q.size() != 0) exp_err = 1'b1;
    if (ex_valid && m_busy(ex_rd)) exp_err = 1'b1;
    if (mem_rsp_valid) begin
      if (pend_q.size() == 0) exp_err = 1'b1;
      else begin
        have = 1'b1;
        wr   = pend_q.pop_front();
        wd   = mem_rsp_data;
      end
      if (ex_valid && ex_wait_q.size() == 0) begin
        e.rd   = ex_rd;
        e.data = ex_data;
        ex_wait_q.push_back(e);
      end
    end else if (ex_wait_q.size() != 0) begin
      e    = ex_wait_q.pop_front();
      have = 1'b1;
      wr   = e.rd;
      wd   = e.data;
    end else if (ex_valid) begin
      have = 1'b1;
      wr   = ex_rd;
      wd   = ex_data;
    end
    if (ld_issue && rdy) pend_q.push_back(ld_rd);
    exp_wb_en = have && (wr != 4'd0);
    if (exp_wb_en) begin
      exp_wb_addr = wr;
      exp_wb_data = wd;
    end
  endfunction

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_rd         = '0;
    ex_data       = '0;
    ld_issue      = 1'b0;
    ld_rd         = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    pend_q.delete();
    ex_wait_q.delete();
    exp_err     = 1'b0;
    exp_wb_en   = 1'b0;
    exp_wb_addr = '0;
    exp_wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_wb_en got %b want 0", wb_en); end
    n_cmp++; if (wb_addr !== 4'd0) begin n_bad++; $display("[TB] FAIL rst_wb_addr got %0d want 0", wb_addr); end
    n_cmp++; if (wb_data !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_wb_data got %h want 0", wb_data); end
    n_cmp++; if (busy !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_busy got %h want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err got %b want 0", err); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_ex_ready got %b want 1", ex_ready); end
    n_cmp++; if (ld_issue_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_ld_ready got %b want 1", ld_issue_ready); end
    do_reset();
  endtask

  task automatic test_ex_write();
    ex_valid = 1'b1; ex_rd = 4'd3; ex_data = 32'hA5A5_0001;
    tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b1) begin n_bad++; $display("[TB] FAIL ex_wb_en got %b want 1", wb_en); end
    n_cmp++; if (wb_addr !== 4'd3) begin n_bad++; $display("[TB] FAIL ex_wb_addr got %0d want 3", wb_addr); end
    n_cmp++; if (wb_data !== 32'hA5A5_0001) begin n_bad++; $display("[TB] FAIL ex_wb_data got %h want a5a50001", wb_data); end
    tick();
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("[TB] FAIL ex_idle_wb_en got %b want 0", wb_en); end
  endtask

  task automatic test_load_ex_merge();
    ld_issue = 1'b1; ld_rd = 4'd5;
    #1;
    n_cmp++; if (ld_issue_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL merge_ld_ready got %b want 1", ld_issue_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (busy !== 16'h0020) begin n_bad++; $display("[TB] FAIL merge_busy5 got %h want 0020", busy); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1234;
    ex_valid = 1'b1; ex_rd = 4'd6; ex_data = 32'h0000_0066;
    tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 4'd5) begin n_bad++; $display("[TB] FAIL merge_first en/addr got %b/%0d want 1/5", wb_en, wb_addr); end
    n_cmp++; if (wb_data !== 32'h0000_1234) begin n_bad++; $display("[TB] FAIL merge_first_data got %h want 00001234", wb_data); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL merge_ex_ready_low got %b want 0", ex_ready); end
    n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("[TB] FAIL merge_busy_clear got %h want 0000", busy); end
    tick();
    n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 4'd6) begin n_bad++; $display("[TB] FAIL merge_skid en/addr got %b/%0d want 1/6", wb_en, wb_addr); end
    n_cmp++; if (wb_data !== 32'h0000_0066) begin n_bad++; $display("[TB] FAIL merge_skid_data got %h want 00000066", wb_data); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL merge_ex_ready_back got %b want 1", ex_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL merge_err got %b want 0", err); end
  endtask

  task automatic test_fifo_full();
    ld_issue = 1'b1; ld_rd = 4'd2; tick();
    ld_rd = 4'd4; tick();
    ld_issue = 1'b0; ld_rd = 4'd9;
    #1;
    n_cmp++; if (ld_issue_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL full_ld_ready got %b want 0", ld_issue_ready); end
    ld_issue = 1'b1; tick();
    idle_inputs();
    n_cmp++; if (busy !== 16'h0014) begin n_bad++; $display("[TB] FAIL full_third_ignored busy got %h want 0014", busy); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11; tick();
    n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 32'h11) begin n_bad++; $display("[TB] FAIL full_rsp1 got %b/%0d/%h want 1/2/11", wb_en, wb_addr, wb_data); end
    mem_rsp_valid = 1'b0; ld_rd = 4'd9;
    #1;
    n_cmp++; if (ld_issue_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL full_ready_back got %b want 1", ld_issue_ready); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h22; tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 4'd4 || wb_data !== 32'h22) begin n_bad++; $display("[TB] FAIL full_rsp2 got %b/%0d/%h want 1/4/22", wb_en, wb_addr, wb_data); end
    n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("[TB] FAIL full_busy_empty got %h want 0000", busy); end
    // Full FIFO with a same-cycle pop and push attempt: only the pop happens.
    ld_issue = 1'b1; ld_rd = 4'd2; tick();
    ld_rd = 4'd4; tick();
    ld_rd = 4'd9; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h33; tick();
    idle_inputs();
    n_cmp++; if (wb_addr !== 4'd2 || wb_data !== 32'h33) begin n_bad++; $display("[TB] FAIL full_pushpop_wb got %0d/%h want 2/33", wb_addr, wb_data); end
    n_cmp++; if (busy !== 16'h0010) begin n_bad++; $display("[TB] FAIL full_pushpop_busy got %h want 0010", busy); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h44; tick();
    idle_inputs();
    n_cmp++; if (wb_addr !== 4'd4 || wb_data !== 32'h44 || busy !== 16'h0000) begin n_bad++; $display("[TB] FAIL full_drain got %0d/%h/%h want 4/44/0000", wb_addr, wb_data, busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL full_err got %b want 0", err); end
  endtask

  task automatic test_busy_refuse();
    ld_issue = 1'b1; ld_rd = 4'd7; tick();
    #1;
    n_cmp++; if (ld_issue_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL busy7_ready got %b want 0", ld_issue_ready); end
    tick();
    idle_inputs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77; tick();
    idle_inputs();
    n_cmp++; if (wb_addr !== 4'd7 || busy !== 16'h0000 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL busy7_single got %0d/%h/%b want 7/0000/0", wb_addr, busy, err); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD; tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("[TB] FAIL spurious_wb_en got %b want 0", wb_en); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL spurious_err got %b want 1", err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_x0_and_reset();
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL x0_err_cleared got %b want 0", err); end
    ex_valid = 1'b1; ex_rd = 4'd0; ex_data = 32'hFFFF_FFFF; tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("[TB] FAIL x0_ex_wb_en got %b want 0", wb_en); end
    ld_issue = 1'b1; ld_rd = 4'd0; tick();
    ld_rd = 4'd3; tick();
    idle_inputs();
    n_cmp++; if (busy !== 16'h0008) begin n_bad++; $display("[TB] FAIL x0_busy got %h want 0008", busy); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF;
    ex_valid = 1'b1; ex_rd = 4'd8; ex_data = 32'h88; tick();
    idle_inputs();
    n_cmp++; if (wb_en !== 1'b0 || ex_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL x0_load_skid en/ready got %b/%b want 0/0", wb_en, ex_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (wb_en !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 32'd0) begin n_bad++; $display("[TB] FAIL midrst_wb got %b/%0d/%h want 0/0/0", wb_en, wb_addr, wb_data); end
    n_cmp++; if (busy !== 16'd0 || ex_ready !== 1'b1 || err !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_state got %h/%b/%b want 0000/1/0", busy, ex_ready, err); end
    do_reset();
    tick();
    n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_skid_flushed got %b want 0", wb_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      idle_inputs();
      if (ex_wait_q.size() == 0 && $urandom_range(0, 1) == 1) begin
        ex_valid = 1'b1;
        ex_rd    = 4'($urandom_range(0, 15));
        if (m_busy(ex_rd)) ex_rd = 4'd0;
        ex_data  = $urandom;
      end
      if (pend_q.size() != 0 && $urandom_range(0, 9) < 4) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = $urandom;
      end
      ld_issue = ($urandom_range(0, 1) == 1);
      ld_rd    = 4'($urandom_range(0, 15));
      #1;
      n_cmp++; if (ld_issue_ready !== m_ld_ready(ld_rd)) begin n_bad++; $display("[TB] FAIL rnd_ld_ready c=%0d got %b want %b", c, ld_issue_ready, m_ld_ready(ld_rd)); end
      tick();
      n_cmp++; if (wb_en !== exp_wb_en) begin n_bad++; $display("[TB] FAIL rnd_wb_en c=%0d got %b want %b", c, wb_en, exp_wb_en); end
      if (exp_wb_en) begin
        n_cmp++; if (wb_addr !== exp_wb_addr || wb_data !== exp_wb_data) begin n_bad++; $display("[TB] FAIL rnd_wb c=%0d got %0d/%h want %0d/%h", c, wb_addr, wb_data, exp_wb_addr, exp_wb_data); end
      end
      n_cmp++; if (busy !== m_busy_vec()) begin n_bad++; $display("[TB] FAIL rnd_busy c=%0d got %h want %h", c, busy, m_busy_vec()); end
      n_cmp++; if (ex_ready !== (ex_wait_q.size() == 0)) begin n_bad++; $display("[TB] FAIL rnd_ex_ready c=%0d got %b want %b", c, ex_ready, ex_wait_q.size() == 0); end
      n_cmp++; if (err !== exp_err) begin n_bad++; $display("[TB] FAIL rnd_err c=%0d got %b want %b", c, err, exp_err); end
`ifdef WB_BYPASS_EN
      n_cmp++; if (byp_valid !== exp_wb_en || (exp_wb_en && (byp_addr !== exp_wb_addr || byp_data !== exp_wb_data))) begin n_bad++; $display("[TB] FAIL rnd_byp c=%0d got %b/%0d/%h", c, byp_valid, byp_addr, byp_data); end
`else
      n_cmp++; if (byp_valid !== 1'b0 || byp_addr !== 4'd0 || byp_data !== 32'd0) begin n_bad++; $display("[TB] FAIL rnd_byp_off c=%0d got %b/%0d/%h want 0/0/0", c, byp_valid, byp_addr, byp_data); end
`endif
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ex_write();
    test_load_ex_merge();
    test_fifo_full();
    test_busy_refuse();
    test_x0_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
